lu_compare_seq: RTL and testbench

LU_COMPARE_SEQ -- requirements
Module: lu_compare_seq

---
 rtl/lu_compare_pkg.sv | 36 +++
 rtl/lu_chunk_cmp.sv | 16 +
 rtl/lu_compare_seq.sv | 139 +++++++++++++
 tb/tb_lu_compare_seq.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/lu_compare_pkg.sv
// Shared types and constants for the sequential chunk-wise magnitude comparator.
// Holds the FSM state encoding, the mode encoding and the mode-to-result mapping.
package lu_compare_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [2:0] MODE_EQ = 3'b000;
    localparam logic [2:0] MODE_NE = 3'b001;
    localparam logic [2:0] MODE_LT = 3'b010;
    localparam logic [2:0] MODE_GT = 3'b011;
    localparam logic [2:0] MODE_LE = 3'b100;
    localparam logic [2:0] MODE_GE = 3'b101;

    // Reserved encodings (110, 111) always evaluate false.
    function automatic logic eval_mode(input logic [2:0] mode,
                                       input logic       is_eq,
                                       input logic       is_lt);
        logic r;
        r = 1'b0;
        case (mode)
            MODE_EQ: r = is_eq;
            MODE_NE: r = !is_eq;
            MODE_LT: r = is_lt;
            MODE_GT: r = !is_eq && !is_lt;
            MODE_LE: r = is_eq || is_lt;
            MODE_GE: r = !is_lt;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lu_chunk_cmp.sv
// Combinational unsigned compare of one DIGIT-bit chunk pair.
module lu_chunk_cmp #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] chunk_a,
    input  logic [DIGIT-1:0] chunk_b,
    output logic             chunk_eq,
    output logic             chunk_lt
);

    always_comb begin
        chunk_eq = (chunk_a == chunk_b);
        chunk_lt = (chunk_a < chunk_b);
    end

endmodule

// File: rtl/lu_compare_seq.sv
// Sequential comparator: scans operands DIGIT bits per cycle, MSB chunk first,
// exiting early on the first differing chunk. Signed compare is done by MSB flip.
module lu_compare_seq
    import lu_compare_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             result,
    output logic             eq,
    output logic             lt
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST_CHUNK = CW'(N - 1);

    state_e           state_q,  state_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [2:0]       mode_q,   mode_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic             result_q, result_d;
    logic             eq_q,     eq_d;
    logic             lt_q,     lt_d;

    logic [WIDTH-1:0] a_sh, b_sh;
    logic [DIGIT-1:0] chunk_a, chunk_b;
    logic             chunk_eq, chunk_lt;
    logic [WIDTH-1:0] sign_flip;

    // Shifting the current chunk up to the MSB end avoids a variable part-select.
    always_comb begin
        a_sh    = a_q << (DIGIT * int'(cnt_q));
        b_sh    = b_q << (DIGIT * int'(cnt_q));
        chunk_a = a_sh[WIDTH-1 -: DIGIT];
        chunk_b = b_sh[WIDTH-1 -: DIGIT];
    end

    lu_chunk_cmp #(
        .DIGIT (DIGIT)
    ) u_chunk_cmp (
        .chunk_a  (chunk_a),
        .chunk_b  (chunk_b),
        .chunk_eq (chunk_eq),
        .chunk_lt (chunk_lt)
    );

    always_comb begin
        sign_flip = '0;
        sign_flip[WIDTH-1] = is_signed;

        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        mode_d   = mode_q;
        result_d = result_q;
        eq_d     = eq_q;
        lt_d     = lt_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d     = a ^ sign_flip;
                    b_d     = b ^ sign_flip;
                    mode_d  = mode;
                    cnt_d   = '0;
                    state_d = ST_SCAN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (!chunk_eq) begin
                    eq_d     = 1'b0;
                    lt_d     = chunk_lt;
                    result_d = eval_mode(mode_q, 1'b0, chunk_lt);
                    state_d  = ST_DONE;
                end else if (cnt_q == LAST_CHUNK) begin
                    eq_d     = 1'b1;
                    lt_d     = 1'b0;
                    result_d = eval_mode(mode_q, 1'b1, 1'b0);
                    state_d  = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_SCAN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 1'b0;
            eq_q     <= 1'b0;
            lt_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mode_q   <= mode_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            eq_q     <= eq_d;
            lt_q     <= lt_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign eq     = eq_q;
    assign lt     = lt_q;

endmodule

// File: tb/tb_lu_compare_seq.sv
// Bench for lu_compare_seq (WIDTH=8, DIGIT=2): vector table plus hand sequences,
// expected results queued at accept and checked when done pulses.
module tb_lu_compare_seq;

    localparam int WIDTH = 8;
    localparam int DIGIT = 2;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [2:0]       mode;
    logic             is_signed;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             busy;
    logic             done;
    logic             result;
    logic             eq;
    logic             lt;

    lu_compare_seq #(
        .WIDTH (WIDTH),
        .DIGIT (DIGIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .is_signed (is_signed),
        .a         (a_i),
        .b         (b_i),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .eq        (eq),
        .lt        (lt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic res;
        logic eq;
        logic lt;
        int   lat;
        int   acc;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] mode;
        logic       sgn;
        logic       res;
        logic       eq;
        logic       lt;
        int         lat;
    } vec_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result",  32'(result), 32'(e.res));
                check("eq",      32'(eq),     32'(e.eq));
                check("lt",      32'(lt),     32'(e.lt));
                check("latency", 32'(cyc - e.acc), 32'(e.lat));
            end
        end
    end

    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic [2:0] m,
                          input logic sg, input logic er, input logic ee, input logic el,
                          input int lat);
        exp_t e;
        @(negedge clk);
        a_i       = av;
        b_i       = bv;
        mode      = m;
        is_signed = sg;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e.res = er;
        e.eq  = ee;
        e.lt  = el;
        e.lat = lat;
        e.acc = cyc;
        sb.push_back(e);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 30 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{8'h25, 8'h25, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 4};
        vecs[1]  = '{8'h65, 8'h25, 3'b011, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        vecs[2]  = '{8'h80, 8'h01, 3'b010, 1'b1, 1'b1, 1'b0, 1'b1, 1};
        vecs[3]  = '{8'h80, 8'h01, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        vecs[4]  = '{8'h12, 8'h13, 3'b001, 1'b0, 1'b1, 1'b0, 1'b1, 4};
        vecs[5]  = '{8'h34, 8'h30, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 3};
        vecs[6]  = '{8'h30, 8'h34, 3'b100, 1'b0, 1'b1, 1'b0, 1'b1, 3};
        vecs[7]  = '{8'hFF, 8'hFF, 3'b101, 1'b1, 1'b1, 1'b1, 1'b0, 4};
        vecs[8]  = '{8'hFF, 8'h01, 3'b011, 1'b1, 1'b0, 1'b0, 1'b1, 1};
        vecs[9]  = '{8'h42, 8'h4A, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 3};
        vecs[10] = '{8'h7F, 8'h80, 3'b010, 1'b0, 1'b1, 1'b0, 1'b1, 1};
        vecs[11] = '{8'h7F, 8'h80, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        vecs[12] = '{8'h55, 8'h55, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 4};
        vecs[13] = '{8'hA0, 8'hA1, 3'b101, 1'b1, 1'b0, 1'b0, 1'b1, 4};

        rst_n = 1'b0;
        start = 1'b0;
        mode = '0;
        is_signed = 1'b0;
        a_i = '0;
        b_i = '0;
        repeat (3) @(negedge clk);
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_done",   32'(done),   32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_eq",     32'(eq),     32'd0);
        check("rst_lt",     32'(lt),     32'd0);
        rst_n = 1'b1;

        // Table vectors, each run to completion.
        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].mode, vecs[i].sgn,
                   vecs[i].res, vecs[i].eq, vecs[i].lt, vecs[i].lat);
            wait_drain();
        end

        // Start during SCAN with different operands must be ignored.
        run_op(8'h24, 8'h25, 3'b101, 1'b0, 1'b0, 1'b0, 1'b1, 4);
        @(negedge clk);
        check("scan_busy", 32'(busy), 32'd1);
        a_i   = 8'hFF;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_drain();
        repeat (3) @(negedge clk);
        check("idle_after_done", 32'(busy), 32'd0);

        // Back-to-back: second start accepted while done is high.
        run_op(8'h65, 8'h25, 3'b011, 1'b0, 1'b1, 1'b0, 1'b0, 1);
        @(negedge clk);
        run_op(8'h10, 8'h20, 3'b110, 1'b0, 1'b0, 1'b0, 1'b1, 2);
        @(negedge clk);
        check("b2b_busy", 32'(busy), 32'd1);
        wait_drain();

        // Reset mid-SCAN: outputs clear at once, no done for the aborted op.
        run_op(8'h25, 8'h25, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 4);
        wait_drain();
        run_op(8'h25, 8'h25, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 4);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("arst_busy",   32'(busy),   32'd0);
        check("arst_done",   32'(done),   32'd0);
        check("arst_result", 32'(result), 32'd0);
        check("arst_eq",     32'(eq),     32'd0);
        check("arst_lt",     32'(lt),     32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("post_rst_idle", 32'(busy), 32'd0);
        run_op(8'h3C, 8'h3D, 3'b010, 1'b0, 1'b1, 1'b0, 1'b1, 4);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
